bram_accum: RTL and testbench
=============================

BRAM_ACCUM -- requirements
Module: bram_accum

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning counter width per entry.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning entry count DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter INC_WIDTH, default 16, meaning increment width; INC_WIDTH <= DATA_WIDTH.
REQ-004 SHALL have parameter SATURATE, default 1, meaning 1 = clamp at max and 0 = wrap modulo 2**DATA_WIDTH.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port i_wr, input, 1 bit: accumulate request strobe.
REQ-008 SHALL have port i_addr, input, ADDR_WIDTH bits: accumulate target entry.
REQ-009 SHALL have port i_data, input, INC_WIDTH bits: unsigned increment, zero-extended.
REQ-010 SHALL have port i_clear, input, 1 bit: pulse that starts a clear sweep of all entries.
REQ-011 SHALL have port o_rd, input, 1 bit: read request strobe.
REQ-012 SHALL have port o_addr, input, ADDR_WIDTH bits: read entry.
REQ-013 SHALL have port o_data, output, DATA_WIDTH bits: registered read data.
REQ-014 SHALL have port o_valid, output, 1 bit: o_data valid pulse.
REQ-015 SHALL have port o_busy, output, 1 bit: clear sweep in progress.
REQ-016 SHALL have port o_drop, output, 1 bit: one-cycle pulse when an accumulate is discarded.

Function
REQ-017 Entries SHALL be held in a single inferred RAM of DEPTH x DATA_WIDTH with a synchronous read port and a write port.
REQ-018 An accumulate accepted at cycle t (i_wr=1, o_busy=0, i_clear=0) SHALL update mem[i_addr] to f(mem[i_addr] + i_data); the result SHALL be visible to a read issued at cycle t+2 or later.
REQ-019 f: SATURATE=1 gives min(sum, 2**DATA_WIDTH-1); SATURATE=0 gives sum mod 2**DATA_WIDTH.
REQ-020 Accumulates SHALL be accepted every cycle with no stall; each accepted request SHALL be applied exactly once for any address sequence, including back-to-back and alternating same-address requests (internal forwarding required).
REQ-021 A read with o_rd=1 at cycle t SHALL drive o_valid=1 and o_data at cycle t+1.
REQ-022 o_data SHALL equal the entry including all accumulates accepted at cycle t-2 or earlier; accumulates accepted at t-1 or t SHALL NOT be reflected.
REQ-023 o_valid SHALL be 0 and o_data SHALL hold its previous value in every cycle not following a read.
REQ-024 On i_clear=1 the block SHALL assert o_busy from the next cycle for exactly DEPTH cycles, writing 0 to entries 0..DEPTH-1 in ascending order, one per cycle.
REQ-025 i_clear during o_busy SHALL restart the sweep at entry 0, with o_busy remaining high DEPTH cycles from the restart.
REQ-026 i_wr while o_busy=1 or i_clear=1 SHALL be discarded and o_drop SHALL pulse in the following cycle.
REQ-027 An accumulate in flight when i_clear is sampled SHALL be cancelled, and no post-clear write SHALL occur.
REQ-028 A read while o_busy=1 SHALL return o_data=0 with o_valid=1.
REQ-029 After o_busy falls, all entries SHALL read 0.
REQ-030 Simultaneous i_wr and o_rd to the same address SHALL follow REQ-022, returning the pre-accumulate value.

Reset
REQ-031 While rst=1: o_data=0, o_valid=0, o_drop=0, o_busy=0, pipeline cancelled.
REQ-032 In the first cycle after rst falls, the block SHALL start a clear sweep as if i_clear had been pulsed, so o_busy=1 for DEPTH cycles.
REQ-033 rst asserted mid-sweep or mid-accumulate SHALL abort the operation and restart the sweep after release.

Verification
REQ-034 Reset, then wait for o_busy to fall, then read all 256 entries -> each o_data=0, with o_busy high exactly 256 cycles.
REQ-035 Five back-to-back i_wr to addr 0x10 with data 1,2,3,4,5, then read at +2 -> o_data=15.
REQ-036 Alternating i_wr to 0x01/0x02, 100 cycles, data 7 -> each reads 350.
REQ-037 SATURATE=1 with DATA_WIDTH=8: entry at 250, add 10 -> 255; SATURATE=0 -> 4.
REQ-038 i_wr to 0x20 (data 9) on the same cycle as i_clear -> o_drop pulses, and 0x20 reads 0 after the sweep.
REQ-039 i_wr addr 0x30 data 3 with o_rd 0x30 in the same cycle -> old value; read two cycles later -> old+3.

Source files
------------

// File: rtl/bram_accum.sv
// bram_accum: an array of DEPTH counters held in one inferred RAM.
// Each accepted accumulate does a read-modify-write: the RAM is read in the accept cycle
// and written back one cycle later. A one-entry forwarding register covers back-to-back
// hits on the same entry. A clear sweep zeroes every entry in ascending order, one per
// cycle. Reads return registered data one cycle after the request.
module bram_accum #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned INC_WIDTH  = 16,
    parameter bit          SATURATE   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [INC_WIDTH-1:0]  i_data,
    input  logic                  i_clear,
    input  logic                  o_rd,
    input  logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_busy,
    output logic                  o_drop
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        StStart,
        StRun,
        StSweep
    } state_e;

    state_e state_q, state_d;

    // Counter storage
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // RAM read registers: port A feeds the accumulate pipe, port B feeds the user read
    logic [DATA_WIDTH-1:0] rda_q;
    logic [DATA_WIDTH-1:0] rdb_q;

    // Accumulate pipeline stage 1 (one cycle after acceptance)
    logic                  s1_v_q;
    logic [ADDR_WIDTH-1:0] s1_addr_q;
    logic [INC_WIDTH-1:0]  s1_inc_q;

    // Last accumulate write, for same-address forwarding
    logic                  fwd_v_q;
    logic [ADDR_WIDTH-1:0] fwd_addr_q;
    logic [DATA_WIDTH-1:0] fwd_data_q;

    logic [ADDR_WIDTH-1:0] sweep_q;
    logic                  valid_q;
    logic                  zero_q;
    logic                  drop_q;

    // FSM decoded outputs
    logic busy;
    logic start;

    // Combinational datapath
    logic                  clr;
    logic                  acc;
    logic [DATA_WIDTH-1:0] old_val;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH-1:0] acc_res;
    logic                  acc_we;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StStart;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a clear (or the first cycle out of reset) always (re)starts the sweep
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = StSweep;
        end else if (state_q == StSweep && sweep_q == '1) begin
            state_d = StRun;
        end
    end

    // FSM outputs
    always_comb begin
        busy  = 1'b0;
        start = 1'b0;
        unique case (state_q)
            StStart: start = 1'b1;
            StSweep: busy  = 1'b1;
            default: ;
        endcase
    end

    // Accept logic, forwarding mux, saturating/wrapping add and write-port select
    always_comb begin
        clr     = i_clear | start;
        acc     = i_wr & ~busy & ~clr;
        old_val = (fwd_v_q && fwd_addr_q == s1_addr_q) ? fwd_data_q : rda_q;
        sum     = {1'b0, old_val} + (DATA_WIDTH + 1)'(s1_inc_q);
        if (SATURATE && sum[DATA_WIDTH]) begin
            acc_res = '1;
        end else begin
            acc_res = sum[DATA_WIDTH-1:0];
        end
        // A clear sampled in the same cycle cancels the pending write-back
        acc_we    = s1_v_q & ~clr & ~rst;
        mem_we    = acc_we | (busy & ~rst);
        mem_waddr = busy ? sweep_q : s1_addr_q;
        mem_wdata = busy ? '0 : acc_res;
    end

    // Inferred RAM: read-first on both read ports, so same-cycle writes are not seen
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        rda_q <= mem[i_addr];
        if (o_rd) begin
            rdb_q <= mem[o_addr];
        end
    end

    // Control registers with reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_q <= '0;
            s1_v_q  <= 1'b0;
            fwd_v_q <= 1'b0;
            valid_q <= 1'b0;
            zero_q  <= 1'b1;
            drop_q  <= 1'b0;
        end else begin
            s1_v_q  <= acc;
            fwd_v_q <= acc_we;
            valid_q <= o_rd;
            drop_q  <= i_wr & (busy | clr);
            // Reads during a sweep return zero; the flag holds along with rdb_q
            if (o_rd) begin
                zero_q <= busy;
            end
            if (clr) begin
                sweep_q <= '0;
            end else if (busy) begin
                sweep_q <= sweep_q + 1'b1;
            end
        end
    end

    // Pipeline payload registers (qualified by their valid bits, so no reset needed)
    always_ff @(posedge clk) begin
        s1_addr_q  <= i_addr;
        s1_inc_q   <= i_data;
        fwd_addr_q <= s1_addr_q;
        fwd_data_q <= acc_res;
    end

    // Output drive
    always_comb begin
        o_data  = zero_q ? '0 : rdb_q;
        o_valid = valid_q;
        o_busy  = busy;
        o_drop  = drop_q;
    end

endmodule

// File: tb/tb_bram_accum.sv
// Self-checking bench for bram_accum: directed scenarios plus randomized traffic,
// checked against an array model with a two-cycle visibility delay.
module tb_bram_accum;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_wr, i_clear, o_rd;
    logic [7:0]  i_addr, o_addr;
    logic [15:0] i_data;
    logic [31:0] o_data;
    logic        o_valid, o_busy, o_drop;

    // Small 8-bit instances for saturate vs wrap
    logic       s_wr, s_clear, s_rd;
    logic [1:0] s_addr;
    logic [7:0] s_data;
    logic [7:0] sat_data, wrap_data;
    logic       sat_valid, sat_busy, sat_drop;
    logic       wrap_valid, wrap_busy, wrap_drop;

    always #5 clk = ~clk;

    bram_accum dut (
        .clk(clk), .rst(rst), .i_wr(i_wr), .i_addr(i_addr), .i_data(i_data),
        .i_clear(i_clear), .o_rd(o_rd), .o_addr(o_addr), .o_data(o_data),
        .o_valid(o_valid), .o_busy(o_busy), .o_drop(o_drop)
    );

    bram_accum #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .INC_WIDTH(8), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .i_wr(s_wr), .i_addr(s_addr), .i_data(s_data),
        .i_clear(s_clear), .o_rd(s_rd), .o_addr(s_addr), .o_data(sat_data),
        .o_valid(sat_valid), .o_busy(sat_busy), .o_drop(sat_drop)
    );

    bram_accum #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .INC_WIDTH(8), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .i_wr(s_wr), .i_addr(s_addr), .i_data(s_data),
        .i_clear(s_clear), .o_rd(s_rd), .o_addr(s_addr), .o_data(wrap_data),
        .o_valid(wrap_valid), .o_busy(wrap_busy), .o_drop(wrap_drop)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: entry values, accepted ops awaiting visibility, busy window
    typedef struct {
        int              cyc;
        int              addr;
        longint unsigned data;
    } op_t;

    longint unsigned model [DEPTH];
    op_t             pend[$];
    int              cyc = 0;
    int              busy_left = 0;
    bit              start_pending = 1'b0;
    logic [31:0]     exp_data = '0;
    int              busy_seen = 0;

    function automatic longint unsigned sat32(input longint unsigned s);
        return (s > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : s;
    endfunction

    task automatic idle();
        i_wr = 1'b0; i_clear = 1'b0; o_rd = 1'b0;
        i_addr = '0; o_addr = '0; i_data = '0;
    endtask

    // One clock: predict from the current inputs, advance, then compare outputs
    task automatic tick();
        bit  busy_now, clr, exp_valid, exp_drop;
        op_t op;
        busy_now = (busy_left > 0);
        clr      = i_clear || start_pending;
        check("busy", o_busy, busy_now);
        if (o_busy) busy_seen++;
        // Accepts from two or more cycles ago are visible to reads now
        while (pend.size() > 0 && pend[0].cyc <= cyc - 2) begin
            op = pend.pop_front();
            model[op.addr] = sat32(model[op.addr] + op.data);
        end
        exp_valid = o_rd;
        if (o_rd) exp_data = busy_now ? 32'd0 : 32'(model[o_addr]);
        exp_drop = i_wr && (busy_now || clr);
        if (i_wr && !busy_now && !clr) pend.push_back('{cyc, int'(i_addr), longint'(i_data)});
        if (clr) begin
            pend.delete();
            foreach (model[k]) model[k] = 0;
            busy_left     = DEPTH;
            start_pending = 1'b0;
        end else if (busy_left > 0) begin
            busy_left--;
        end
        @(posedge clk);
        #1;
        cyc++;
        check("valid", o_valid, exp_valid);
        check("data", o_data, exp_data);
        check("drop", o_drop, exp_drop);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_data", o_data, 32'd0);
            check("rst_valid", o_valid, 1'b0);
            check("rst_busy", o_busy, 1'b0);
            check("rst_drop", o_drop, 1'b0);
        end
        rst = 1'b0;
        pend.delete();
        busy_left     = 0;
        start_pending = 1'b1;
        exp_data      = '0;
    endtask

    task automatic rd(input logic [7:0] a);
        o_rd = 1'b1; o_addr = a;
        tick();
        o_rd = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        i_wr = 1'b1; i_addr = a; i_data = d;
        tick();
        i_wr = 1'b0;
    endtask

    initial begin
        s_wr = 1'b0; s_clear = 1'b0; s_rd = 1'b0; s_addr = '0; s_data = '0;
        do_reset();

        // Post-reset sweep: busy for exactly DEPTH cycles, then every entry reads zero
        busy_seen = 0;
        repeat (DEPTH + 2) tick();
        check("busy_cycles", busy_seen, DEPTH);
        for (int a = 0; a < DEPTH; a++) begin
            rd(8'(a));
            check("sweep_zero", o_data, 32'd0);
        end

        // 8-bit saturate vs wrap: 250 + 10
        s_wr = 1'b1; s_addr = 2'd1; s_data = 8'd250; tick();
        s_data = 8'd10; tick();
        s_wr = 1'b0; tick();
        s_rd = 1'b1; tick();
        s_rd = 1'b0;
        check("sat_valid", sat_valid, 1'b1);
        check("sat_data", sat_data, 8'd255);
        check("wrap_data", wrap_data, 8'd4);

        // Five back-to-back accumulates to one entry
        for (int i = 1; i <= 5; i++) wr(8'h10, 16'(i));
        tick();
        rd(8'h10);
        check("b2b_sum", o_data, 32'd15);

        // Alternating addresses
        for (int i = 0; i < 100; i++) wr((i % 2) ? 8'h02 : 8'h01, 16'd7);
        tick();
        rd(8'h01);
        check("alt_01", o_data, 32'd350);
        rd(8'h02);
        check("alt_02", o_data, 32'd350);

        // Same-cycle accumulate and read return the old value; two cycles later the new one
        wr(8'h30, 16'd11);
        tick();
        i_wr = 1'b1; i_addr = 8'h30; i_data = 16'd3; o_rd = 1'b1; o_addr = 8'h30;
        tick();
        idle();
        check("same_cyc_old", o_data, 32'd11);
        tick();
        rd(8'h30);
        check("same_cyc_new", o_data, 32'd14);

        // Accumulate coincident with clear is dropped and the entry ends at zero
        wr(8'h20, 16'd5);
        i_wr = 1'b1; i_addr = 8'h20; i_data = 16'd9; i_clear = 1'b1;
        tick();
        idle();
        check("clr_drop", o_drop, 1'b1);
        repeat (DEPTH + 1) tick();
        rd(8'h20);
        check("clr_zero", o_data, 32'd0);

        // Randomized traffic over a small address window to stress forwarding
        for (int n = 0; n < 3000; n++) begin
            i_wr    = ($urandom_range(0, 3) != 0);
            i_addr  = 8'($urandom_range(0, 7));
            i_data  = 16'($urandom);
            o_rd    = $urandom_range(0, 1) == 1;
            o_addr  = 8'($urandom_range(0, 7));
            i_clear = ($urandom_range(0, 399) == 0);
            tick();
        end
        idle();

        // Reset in the middle of a sweep, then verify the restarted sweep
        i_clear = 1'b1; tick(); idle();
        repeat (50) tick();
        wr(8'h05, 16'd1);
        do_reset();
        busy_seen = 0;
        repeat (DEPTH + 2) tick();
        check("rst_busy_cycles", busy_seen, DEPTH);
        for (int a = 0; a < 8; a++) rd(8'(a));

        // Short random burst after the restart
        for (int n = 0; n < 500; n++) begin
            i_wr    = $urandom_range(0, 1) == 1;
            i_addr  = 8'($urandom_range(0, 3));
            i_data  = 16'($urandom);
            o_rd    = $urandom_range(0, 1) == 1;
            o_addr  = 8'($urandom_range(0, 3));
            i_clear = 1'b0;
            tick();
        end
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
